// File: rtl/freq_bcd_counter.sv
// Gated BCD frequency counter: counts synchronized fx rises while enabled, latches on Latch_EN rise.
// Latency fx->counter SYNC_STAGES+1 clks, no backpressure; `define FREQ_OVF_SATURATE_EN holds at all-9s on overflow.
module freq_bcd_counter #(
  parameter int DIGITS      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fx,
  input  logic                Counter_EN,
  input  logic                Latch_EN,
  input  logic                Counter_Clr,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                over_flag,
  output logic                data_valid
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [SYNC_STAGES-1:0] fx_sync_q, fx_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d;
  logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
  logic                   fx_dly_q, fx_dly_d;
  logic                   lat_dly_q, lat_dly_d;
  logic [W-1:0]           counter_q, counter_d;
  logic                   ovf_q, ovf_d;
  logic [W-1:0]           bcd_q, bcd_d;
  logic                   over_q, over_d;
  logic                   valid_q, valid_d;

  logic fx_s, en_s, lat_s, clr_s;
  logic fx_rise, lat_rise;

  // Ripple BCD increment: each digit at 9 rolls to 0 and passes the carry upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    fx_sync_d  = {fx_sync_q[SYNC_STAGES-2:0], fx};
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], Counter_EN};
    lat_sync_d = {lat_sync_q[SYNC_STAGES-2:0], Latch_EN};
    clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], Counter_Clr};
  end

  assign fx_s     = fx_sync_q[SYNC_STAGES-1];
  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign lat_s    = lat_sync_q[SYNC_STAGES-1];
  assign clr_s    = clr_sync_q[SYNC_STAGES-1];
  assign fx_rise  = fx_s & ~fx_dly_q;
  assign lat_rise = lat_s & ~lat_dly_q;

  always_comb begin
    fx_dly_d  = fx_s;
    lat_dly_d = lat_s;
    counter_d = counter_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    over_d    = over_q;
    valid_d   = 1'b0;

    // Clear dominates, including the illegal overlap with the gate window.
    if (clr_s) begin
      counter_d = '0;
      ovf_d     = 1'b0;
    end else if (en_s && fx_rise) begin
      if (counter_q == ALL_NINES) begin
        ovf_d = 1'b1;
`ifdef FREQ_OVF_SATURATE_EN
        counter_d = ALL_NINES;
`else
        counter_d = '0;
`endif
      end else begin
        counter_d = bcd_inc(counter_q);
      end
    end

    // Capture the registered count, so a same-clk count edge lands only in the counter.
    if (lat_rise) begin
      bcd_d   = counter_q;
      over_d  = ovf_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fx_sync_q  <= '0;
      en_sync_q  <= '0;
      lat_sync_q <= '0;
      clr_sync_q <= '0;
      fx_dly_q   <= 1'b0;
      lat_dly_q  <= 1'b0;
      counter_q  <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      over_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      fx_sync_q  <= fx_sync_d;
      en_sync_q  <= en_sync_d;
      lat_sync_q <= lat_sync_d;
      clr_sync_q <= clr_sync_d;
      fx_dly_q   <= fx_dly_d;
      lat_dly_q  <= lat_dly_d;
      counter_q  <= counter_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      over_q     <= over_d;
      valid_q    <= valid_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign over_flag  = over_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_freq_bcd_counter.sv
// Randomized bench for freq_bcd_counter against an integer-count reference model.
module tb_freq_bcd_counter;
  localparam int DIGITS = 4;
  localparam int SYNC   = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fx = 1'b0;
  logic         Counter_EN = 1'b0;
  logic         Latch_EN = 1'b0;
  logic         Counter_Clr = 1'b0;
  logic [W-1:0] bcd_out;
  logic         over_flag;
  logic         data_valid;

  int           total = 0;
  int           bad = 0;
  int           dv_cnt = 0;
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] last_bcd = '0;
  bit           last_ovf = 1'b0;

  freq_bcd_counter #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .fx(fx), .Counter_EN(Counter_EN), .Latch_EN(Latch_EN),
    .Counter_Clr(Counter_Clr), .bcd_out(bcd_out), .over_flag(over_flag), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic model_edge();
    if (Counter_Clr) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else if (Counter_EN) begin
      if (m_cnt == MAXV) begin
        m_ovf = 1'b1;
`ifndef FREQ_OVF_SATURATE_EN
        m_cnt = 0;
`endif
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic pulses(input int n, input bit fast);
    for (int k = 0; k < n; k++) begin
      fx = 1'b1;
      cyc(2);
      fx = 1'b0;
      cyc(fast ? 3 : int'($urandom_range(3, 4)));
      model_edge();
    end
  endtask

  task automatic set_en(input bit v);
    Counter_EN = v;
    cyc(4);
  endtask

  task automatic do_clear();
    Counter_Clr = 1'b1;
    cyc(6);
    Counter_Clr = 1'b0;
    cyc(4);
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic latch_check(input string tag);
    int d0;
    check({tag, "_hold_bcd"}, 32'(bcd_out), 32'(last_bcd));
    check({tag, "_hold_ovf"}, 32'(over_flag), 32'(last_ovf));
    d0 = dv_cnt;
    Latch_EN = 1'b1;
    cyc(SYNC + 3);
    last_bcd = to_bcd(m_cnt);
    last_ovf = m_ovf;
    check({tag, "_bcd"}, 32'(bcd_out), 32'(last_bcd));
    check({tag, "_ovf"}, 32'(over_flag), 32'(last_ovf));
    check({tag, "_dv"}, 32'(dv_cnt - d0), 32'd1);
    check({tag, "_digits"}, 32'(digits_ok(bcd_out)), 32'd1);
    cyc(6);
    check({tag, "_dv_once"}, 32'(dv_cnt - d0), 32'd1);
    Latch_EN = 1'b0;
    cyc(4);
  endtask

  initial begin
    logic [W-1:0] exp_bcd;
    int d0;

    cyc(3);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(over_flag), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_cnt", 32'(dut.counter_q), 32'd0);
    rst = 1'b0;
    cyc(2);

    set_en(1'b1);
    pulses(1250, 1'b0);
    set_en(1'b0);
    latch_check("basic");
    do_clear();
    check("basic_cleared", 32'(dut.counter_q), 32'd0);

    // Reset mid-window with 0123 in the counter and 1250 on the display.
    set_en(1'b1);
    pulses(123, 1'b0);
    check("mid_cnt", 32'(dut.counter_q), 32'h0123);
    rst = 1'b1;
    Counter_EN = 1'b0;
    cyc(1);
    check("mid_rst_cnt", 32'(dut.counter_q), 32'd0);
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_ovf", 32'(over_flag), 32'd0);
    check("mid_rst_dv", 32'(data_valid), 32'd0);
    rst = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    last_bcd = '0;
    last_ovf = 1'b0;
    cyc(4);

    set_en(1'b1);
    pulses(999, 1'b0);
    check("carry_0999", 32'(dut.counter_q), 32'h0999);
    pulses(1, 1'b0);
    check("carry_1000", 32'(dut.counter_q), 32'h1000);
    pulses(9, 1'b0);
    set_en(1'b0);
    latch_check("carry");
    do_clear();

    pulses(500, 1'b0);
    check("gate_cnt", 32'(dut.counter_q), 32'd0);
    latch_check("gate");

    // fx rise and Latch_EN rise presented together reach the core in the same clk.
    set_en(1'b1);
    pulses(5, 1'b0);
    exp_bcd = to_bcd(m_cnt);
    d0 = dv_cnt;
    fx = 1'b1;
    Latch_EN = 1'b1;
    cyc(2);
    fx = 1'b0;
    cyc(4);
    model_edge();
    check("simul_bcd", 32'(bcd_out), 32'(exp_bcd));
    check("simul_cnt", 32'(dut.counter_q), 32'(to_bcd(m_cnt)));
    check("simul_dv", 32'(dv_cnt - d0), 32'd1);
    last_bcd = exp_bcd;
    last_ovf = m_ovf;
    Latch_EN = 1'b0;
    cyc(3);
    set_en(1'b0);
    latch_check("simul_relatch");

    Counter_Clr = 1'b1;
    m_cnt = 0;
    m_ovf = 1'b0;
    cyc(4);
    set_en(1'b1);
    pulses(10, 1'b0);
    check("clr_en_cnt", 32'(dut.counter_q), 32'd0);
    set_en(1'b0);
    Counter_Clr = 1'b0;
    cyc(4);
    latch_check("clr_en");

    repeat (6) begin
      set_en(1'b1);
      pulses(int'($urandom_range(0, 200)), 1'b0);
      set_en(1'b0);
      if ($urandom_range(0, 1) == 1) pulses(int'($urandom_range(0, 20)), 1'b0);
      latch_check("rand");
      if ($urandom_range(0, 1) == 1) do_clear();
    end

    do_clear();
    set_en(1'b1);
    pulses(MAXV + 2, 1'b1);
    set_en(1'b0);
    latch_check("ovf");

    do_clear();
    set_en(1'b1);
    pulses(10, 1'b0);
    set_en(1'b0);
    latch_check("post_ovf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
